vga_line_fetcher: RTL and testbench
===================================

VGA_LINE_FETCHER -- requirements
Module: vga_line_fetcher

Interface
REQ-001 Parameter WORDS_PER_LINE, default 160, meaning 32-bit words per scan line; SHALL be a multiple of BURST_LEN.
REQ-002 Parameter BURST_LEN, default 16, meaning words returned per memory burst.
REQ-003 Parameter FB_BASE, default 32'h0000_0000, meaning framebuffer word address of line 0.
REQ-004 Port sdram_clk  in  1  single clock. One clock; reset is synchronous and active-high.
REQ-005 Port reset  in  1  synchronous active-high reset.
REQ-006 Port line_start  in  1  one-cycle pulse: fetch line line_idx into back bank.
REQ-007 Port line_idx  in  10  line number, sampled on line_start.
REQ-008 Port swap  in  1  one-cycle pulse: exchange front/back banks.
REQ-009 Port vga_ren  out  1  burst read request to memory controller.
REQ-010 Port vga_addr  out  32  burst start word address; stable while vga_ren high.
REQ-011 Port vga_ack  in  1  qualifies vga_data for one word.
REQ-012 Port vga_data  in  32  returned read word.
REQ-013 Port rd_addr  in  8  pixel-side word index into front bank.
REQ-014 Port rd_data  out  32  front-bank word at rd_addr, registered.
REQ-015 Port busy  out  1  high from accepted line_start until done.
REQ-016 Port done  out  1  one-cycle pulse, line fully written.
REQ-017 Port overrun  out  1  sticky error flag.

Function
REQ-018 Storage: two banks of WORDS_PER_LINE x 32; front bank = front_sel, back bank = ~front_sel.
REQ-019 States: IDLE, REQ, RECV, NEXT, DONE.
REQ-020 IDLE: line_start -> latch line_base = FB_BASE + line_idx*WORDS_PER_LINE (32-bit, modulo 2^32), burst_cnt=0, word_cnt=0, busy=1, go REQ.
REQ-021 REQ: vga_ren=1, vga_addr = line_base + burst_cnt*BURST_LEN; stay in REQ until first vga_ack.
REQ-022 The first vga_ack SHALL drop vga_ren in the following cycle and move to RECV; the word it qualifies SHALL be stored.
REQ-023 Every cycle with vga_ack=1 in REQ or RECV SHALL write vga_data into back bank at burst_cnt*BURST_LEN + word_cnt, then word_cnt+1.
REQ-024 When word_cnt reaches BURST_LEN -> NEXT; vga_ack arriving in NEXT, DONE or IDLE SHALL be ignored, not stored.
REQ-025 NEXT: one idle cycle with vga_ren=0 (lets the controller return to idle); burst_cnt+1; if burst_cnt was WORDS_PER_LINE/BURST_LEN-1 -> DONE, else word_cnt=0 -> REQ.
REQ-026 DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-027 line_start while busy=1 SHALL be ignored and set overrun.
REQ-028 swap while busy=0 SHALL toggle front_sel next cycle; swap while busy=1 SHALL be ignored and set overrun.
REQ-029 swap and line_start in the same IDLE cycle: toggle front_sel first; the fetch fills the new back bank.
REQ-030 rd_data SHALL equal front-bank word at rd_addr sampled one cycle earlier; rd_addr >= WORDS_PER_LINE returns 0.
REQ-031 Write and read ports are independent; a read of the front bank is never disturbed by back-bank writes.
REQ-032 Watchdog: 12-bit counter, cleared on each vga_ack and on state entry; reaching 4095 in REQ or RECV SHALL drop vga_ren, set overrun, pulse done, and return to IDLE.

Reset
REQ-033 On reset the module SHALL set state=IDLE, vga_ren=0, vga_addr=0, busy=0, done=0, overrun=0, front_sel=0, rd_data=0, all counters 0.
REQ-034 Bank contents SHALL not be cleared by reset.
REQ-035 Reset mid-burst SHALL abandon the fetch; vga_ack after reset is ignored.
REQ-036 overrun SHALL clear only on reset.

Verification
REQ-037 line_start, line_idx=2, FB_BASE=0, memory model with 5-cycle latency and 16 ack'd words -> vga_addr 320,336,...,464 (10 bursts), done one cycle after final NEXT, busy high throughout.
REQ-038 After REQ-037 fill, swap, sweep rd_addr 0..159 -> rd_data = model word (320+i), one-cycle latency; rd_addr=200 -> 0.
REQ-039 line_start pulsed again mid-fetch and swap mid-fetch -> both ignored, overrun=1, fetch addresses unchanged, front_sel unchanged.
REQ-040 Model withholds vga_ack -> vga_ren high 4095 cycles, then vga_ren=0, overrun=1, done pulse, busy=0.
REQ-041 Reset asserted on 8th word of burst 3 -> next cycle vga_ren=0, busy=0, overrun=0, front_sel=0; stray vga_ack ignored; fresh line_start fetches normally.

Source files
------------

// File: rtl/vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_fetcher
// Purpose  : Double-banked scan-line buffer filled by memory bursts.
// Revision : 1.0
// ============================================================================
module vga_line_fetcher #(
   parameter int          WORDS_PER_LINE = 160,
   parameter int          BURST_LEN      = 16,
   parameter logic [31:0] FB_BASE        = 32'h0000_0000
) (
   input  logic        sdram_clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [9:0]  line_idx,
   input  logic        swap,
   output logic        vga_ren,
   output logic [31:0] vga_addr,
   input  logic        vga_ack,
   input  logic [31:0] vga_data,
   input  logic [7:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   localparam int          c_nbursts   = WORDS_PER_LINE / BURST_LEN;
   localparam int          c_bw        = $clog2(c_nbursts + 1);
   localparam int          c_ww        = $clog2(BURST_LEN + 1);
   localparam int          c_aw        = $clog2(2 * WORDS_PER_LINE);
   localparam logic [11:0] c_wdog_last = 12'd4094;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RECV = 3'd2,
      S_NEXT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_line_base;
   logic [31:0]       w_line_base_nxt;
   logic [c_bw-1:0]   r_burst_cnt;
   logic [c_bw-1:0]   w_burst_nxt;
   logic [c_ww-1:0]   r_word_cnt;
   logic [c_ww-1:0]   w_word_nxt;
   logic [11:0]       r_wdog;
   logic [11:0]       w_wdog_nxt;
   logic              r_front_sel;
   logic              w_front_nxt;
   logic              r_overrun;
   logic              w_overrun_nxt;
   logic              w_busy;
   logic              w_we;
   logic [c_aw-1:0]   w_wr_idx;
   logic [c_aw-1:0]   w_rd_idx;
   logic              w_rd_ok;
   logic [31:0]       r_rd_data;
   logic [31:0]       r_mem [0:2*WORDS_PER_LINE-1];

   // Bank 0 occupies the lower half of r_mem, bank 1 the upper half.
   assign w_wr_idx = c_aw'((r_front_sel ? 32'd0 : 32'(WORDS_PER_LINE))
                           + 32'(r_burst_cnt) * 32'(BURST_LEN) + 32'(r_word_cnt));
   assign w_rd_idx = c_aw'((r_front_sel ? 32'(WORDS_PER_LINE) : 32'd0) + 32'(rd_addr));
   assign w_rd_ok  = 32'(rd_addr) < 32'(WORDS_PER_LINE);
   assign w_we     = vga_ack && !reset && ((r_state == S_REQ) || (r_state == S_RECV));

   assign vga_ren  = (r_state == S_REQ);
   assign vga_addr = r_line_base + 32'(r_burst_cnt) * 32'(BURST_LEN);
   assign busy     = w_busy;
   assign done     = (r_state == S_DONE);
   assign overrun  = r_overrun;
   assign rd_data  = r_rd_data;

   always_comb begin
      w_state_nxt     = r_state;
      w_line_base_nxt = r_line_base;
      w_burst_nxt     = r_burst_cnt;
      w_word_nxt      = r_word_cnt;
      w_wdog_nxt      = r_wdog;
      w_front_nxt     = r_front_sel;
      w_overrun_nxt   = r_overrun;
      w_busy          = (r_state == S_REQ) || (r_state == S_RECV) || (r_state == S_NEXT);

      if (swap) begin
         if (w_busy) w_overrun_nxt = 1'b1;
         else        w_front_nxt   = ~r_front_sel;
      end
      if (line_start && w_busy) w_overrun_nxt = 1'b1;

      case (r_state)
         S_IDLE, S_DONE: begin
            w_state_nxt = S_IDLE;
            if (line_start) begin
               w_line_base_nxt = FB_BASE + 32'(line_idx) * 32'(WORDS_PER_LINE);
               w_burst_nxt     = '0;
               w_word_nxt      = '0;
               w_wdog_nxt      = '0;
               w_state_nxt     = S_REQ;
            end
         end
         S_REQ, S_RECV: begin
            if (vga_ack) begin
               w_word_nxt = r_word_cnt + 1'b1;
               w_wdog_nxt = '0;
               if (r_word_cnt == c_ww'(BURST_LEN - 1)) w_state_nxt = S_NEXT;
               else                                    w_state_nxt = S_RECV;
            end else if (r_wdog == c_wdog_last) begin
               // Memory stopped answering: give up on the line.
               w_state_nxt   = S_DONE;
               w_overrun_nxt = 1'b1;
               w_wdog_nxt    = '0;
            end else begin
               w_wdog_nxt = r_wdog + 1'b1;
            end
         end
         S_NEXT: begin
            w_burst_nxt = r_burst_cnt + 1'b1;
            w_wdog_nxt  = '0;
            if (r_burst_cnt == c_bw'(c_nbursts - 1)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_word_nxt  = '0;
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sdram_clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_line_base <= '0;
         r_burst_cnt <= '0;
         r_word_cnt  <= '0;
         r_wdog      <= '0;
         r_front_sel <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_line_base <= w_line_base_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_word_cnt  <= w_word_nxt;
         r_wdog      <= w_wdog_nxt;
         r_front_sel <= w_front_nxt;
         r_overrun   <= w_overrun_nxt;
      end
   end

   always_ff @(posedge sdram_clk) begin
      if (w_we) r_mem[w_wr_idx] <= vga_data;
   end

   always_ff @(posedge sdram_clk) begin
      if (reset)        r_rd_data <= '0;
      else if (w_rd_ok) r_rd_data <= r_mem[w_rd_idx];
      else              r_rd_data <= '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_line_fetcher
// Purpose  : Directed/randomised bench with a bank-level reference model.
// Revision : 1.0
// ============================================================================
module tb_vga_line_fetcher;

   localparam int WPL = 160;
   localparam int BL  = 16;
   localparam int NB  = WPL / BL;

   logic        sdram_clk;
   logic        reset;
   logic        line_start;
   logic [9:0]  line_idx;
   logic        swap;
   logic        vga_ren;
   logic [31:0] vga_addr;
   logic        vga_ack;
   logic [31:0] vga_data;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic        overrun;

   int          n_vec;
   int          n_err;
   logic [31:0] bank_m [2][WPL];
   bit          bank_full [2];
   bit          front_m;

   vga_line_fetcher #(
      .WORDS_PER_LINE (WPL),
      .BURST_LEN      (BL),
      .FB_BASE        (32'h0000_0000)
   ) u_dut (
      .sdram_clk  (sdram_clk),
      .reset      (reset),
      .line_start (line_start),
      .line_idx   (line_idx),
      .swap       (swap),
      .vga_ren    (vga_ren),
      .vga_addr   (vga_addr),
      .vga_ack    (vga_ack),
      .vga_data   (vga_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   initial sdram_clk = 1'b0;
   always #5 sdram_clk = ~sdram_clk;

   task automatic tick();
      @(posedge sdram_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset   = 1'b0;
      front_m = 1'b0;
   endtask

   task automatic do_swap();
      swap = 1'b1;
      tick();
      swap    = 1'b0;
      front_m = !front_m;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < WPL; i++) begin
         rd_addr = 8'(i);
         tick();
         chk(tag, rd_data, bank_m[front_m][i]);
      end
      rd_addr = 8'd200;
      tick();
      chk("rd_out_of_range", rd_data, 32'd0);
   endtask

   // Acts as the memory controller for one whole line and updates the bank model.
   task automatic run_fetch(input int idx, input int lat_lo, input int lat_hi,
                            input bit with_swap, input bit inject, input int rst_burst);
      bit          back;
      int          lat;
      int          t;
      int          prev;
      logic [31:0] d;
      logic [31:0] addr_hold;
      line_idx   = 10'(idx);
      line_start = 1'b1;
      swap       = with_swap;
      tick();
      line_start = 1'b0;
      swap       = 1'b0;
      if (with_swap) front_m = !front_m;
      back = !front_m;
      chk1("busy_after_start", busy, 1'b1);
      for (int b = 0; b < NB; b++) begin
         t = 0;
         while (!vga_ren && t < 50) begin
            tick();
            t++;
         end
         chk1("ren_request", vga_ren, 1'b1);
         if (!vga_ren) return;
         chk("burst_addr", vga_addr, 32'(idx * WPL + b * BL));
         addr_hold = vga_addr;
         lat = $urandom_range(lat_hi, lat_lo);
         for (int l = 1; l < lat; l++) tick();
         if (inject && b == 4) begin
            line_idx   = 10'(idx ^ 5);
            line_start = 1'b1;
            swap       = 1'b1;
            tick();
            line_start = 1'b0;
            swap       = 1'b0;
            chk1("overrun_on_busy_cmd", overrun, 1'b1);
            chk("addr_after_inject", vga_addr, addr_hold);
            chk1("ren_after_inject", vga_ren, 1'b1);
         end
         for (int w = 0; w < BL; w++) begin
            if (w > 0 && $urandom_range(3, 0) == 0) begin
               vga_ack = 1'b0;
               tick();
            end
            d        = $urandom;
            vga_ack  = 1'b1;
            vga_data = d;
            prev     = $urandom_range(WPL - 1, 0);
            rd_addr  = 8'(prev);
            if (b == rst_burst && w == 7) begin
               reset = 1'b1;
               tick();
               reset   = 1'b0;
               front_m = 1'b0;
               chk1("rst_ren", vga_ren, 1'b0);
               chk1("rst_busy", busy, 1'b0);
               chk1("rst_overrun", overrun, 1'b0);
               chk1("rst_done", done, 1'b0);
               chk("rst_rd_data", rd_data, 32'd0);
               for (int s = 0; s < 3; s++) begin
                  vga_data = $urandom;
                  tick();
                  chk1("stray_ack_ren", vga_ren, 1'b0);
               end
               vga_ack = 1'b0;
               tick();
               chk1("stray_ack_busy", busy, 1'b0);
               return;
            end
            tick();
            bank_m[back][b * BL + w] = d;
            chk1("busy_in_fetch", busy, 1'b1);
            if (bank_full[front_m])
               chk("rd_during_fetch", rd_data, bank_m[front_m][prev]);
            if (w == 0) chk1("ren_drop_after_ack", vga_ren, 1'b0);
         end
         vga_ack = 1'b0;
      end
      chk1("done_in_next", done, 1'b0);
      tick();
      chk1("done_pulse", done, 1'b1);
      chk1("busy_at_done", busy, 1'b0);
      chk1("ren_at_done", vga_ren, 1'b0);
      bank_full[back] = 1'b1;
      tick();
      chk1("done_one_cycle", done, 1'b0);
   endtask

   initial begin
      int cnt;
      n_vec      = 0;
      n_err      = 0;
      front_m    = 1'b0;
      bank_full[0] = 1'b0;
      bank_full[1] = 1'b0;
      reset      = 1'b1;
      line_start = 1'b0;
      line_idx   = '0;
      swap       = 1'b0;
      vga_ack    = 1'b0;
      vga_data   = '0;
      rd_addr    = '0;

      tick();
      tick();
      chk1("reset_ren", vga_ren, 1'b0);
      chk("reset_addr", vga_addr, 32'd0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_overrun", overrun, 1'b0);
      chk("reset_rd_data", rd_data, 32'd0);
      reset = 1'b0;
      tick();

      // Line 2, fixed 5-cycle latency, then make it visible.
      run_fetch(2, 5, 5, 1'b0, 1'b0, -1);
      chk1("no_overrun_clean", overrun, 1'b0);
      do_swap();
      sweep("sweep_line2");

      run_fetch($urandom_range(1023, 0), 1, 8, 1'b0, 1'b0, -1);
      // Swap and start in the same idle cycle.
      run_fetch($urandom_range(1023, 0), 1, 8, 1'b1, 1'b0, -1);
      chk1("no_overrun_swap_start", overrun, 1'b0);
      sweep("sweep_after_swap_start");
      do_swap();
      sweep("sweep_swapped_line");

      // Memory never answers.
      line_idx   = 10'($urandom_range(1023, 0));
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      cnt = 0;
      while (vga_ren && cnt < 5000) begin
         cnt++;
         tick();
      end
      chk("wdog_ren_cycles", 32'(cnt), 32'd4095);
      chk1("wdog_ren_low", vga_ren, 1'b0);
      chk1("wdog_overrun", overrun, 1'b1);
      chk1("wdog_done", done, 1'b1);
      chk1("wdog_busy", busy, 1'b0);
      tick();
      chk1("wdog_done_cleared", done, 1'b0);

      do_reset();
      chk1("overrun_cleared_by_reset", overrun, 1'b0);

      // Commands while busy are dropped; front bank must not move.
      run_fetch($urandom_range(1023, 0), 1, 6, 1'b0, 1'b1, -1);
      chk1("overrun_sticky", overrun, 1'b1);
      sweep("sweep_front_kept");
      do_swap();
      sweep("sweep_injected_line");

      // Reset in the middle of burst 3.
      run_fetch($urandom_range(1023, 0), 1, 6, 1'b0, 1'b0, 3);
      sweep("sweep_after_midreset");

      run_fetch($urandom_range(1023, 0), 1, 6, 1'b0, 1'b0, -1);
      do_swap();
      sweep("sweep_fresh_line");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
